// File: rtl/aa_up_pkg.sv
// ============================================================================
// aa_up_pkg : shared encodings for the upstream AA packetizer
// Rev 1.0
// ============================================================================
`default_nettype none

package aa_up_pkg;

  localparam logic [1:0] TUSER_AXIS             = 2'b00;
  localparam logic [1:0] TUSER_AXILITE_WRITE    = 2'b01;
  localparam logic [1:0] TUSER_AXILITE_READ_REQ = 2'b10;
  localparam logic [1:0] TUSER_AXILITE_READ_CPL = 2'b11;

  localparam logic [1:0] TID_UP_UP = 2'b00;
  localparam logic [1:0] TID_UP_AA = 2'b01;
  localparam logic [1:0] TID_UP_LA = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_ADDR = 2'd1,
    ST_WR_DATA = 2'd2,
    ST_RD_CPL  = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/aa_up_rr_arb.sv
// ============================================================================
// aa_up_rr_arb : 2-way round-robin arbiter, req[0]=mailbox write, req[1]=completion
// Rev 1.0
// ============================================================================
`default_nettype none

module aa_up_rr_arb (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic rr_ptr_q;
  logic rr_ptr_d;

  // A lone request wins regardless of the pointer; the pointer always moves past the winner.
  always_comb begin
    gnt      = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (en) begin
      if (req == 2'b11) begin
        gnt = rr_ptr_q ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
      if (gnt[0]) begin
        rr_ptr_d = 1'b1;
      end else if (gnt[1]) begin
        rr_ptr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/aa_upstream_packetizer.sv
// ============================================================================
// aa_upstream_packetizer : AA mailbox writes / read completions -> TID_UP_AA stream beats
// Optional packet counters enabled by macro AA_UP_PKT_CNT_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module aa_upstream_packetizer #(
  parameter int pADDR_WIDTH = 28,
  parameter int pDATA_WIDTH = 32
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic                   mb_wr_valid,
  output logic                   mb_wr_ready,
  input  logic [pADDR_WIDTH-1:0] mb_wr_addr,
  input  logic [3:0]             mb_wr_be,
  input  logic [pDATA_WIDTH-1:0] mb_wr_data,
  input  logic                   rd_cpl_valid,
  output logic                   rd_cpl_ready,
  input  logic [pDATA_WIDTH-1:0] rd_cpl_data,
  output logic [pDATA_WIDTH-1:0] as_is_tdata,
  output logic [3:0]             as_is_tstrb,
  output logic [3:0]             as_is_tkeep,
  output logic                   as_is_tlast,
  output logic [1:0]             as_is_tid,
  output logic [1:0]             as_is_tuser,
  output logic                   as_is_tvalid,
  input  logic                   as_is_tready
`ifdef AA_UP_PKT_CNT_EN
  ,
  output logic [15:0]            wr_pkt_cnt,
  output logic [15:0]            cpl_pkt_cnt
`endif
);

  import aa_up_pkg::*;

  state_e                   state_q, state_d;
  logic [pADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [3:0]               be_q, be_d;
  logic [pDATA_WIDTH-1:0]   data_q, data_d;
  logic [27:0]              addr_ext;
  logic [1:0]               req;
  logic [1:0]               gnt;
  logic                     arb_en;

  assign req          = {rd_cpl_valid, mb_wr_valid};
  assign arb_en       = (state_q == ST_IDLE) && !axis_rst;
  assign mb_wr_ready  = gnt[0];
  assign rd_cpl_ready = gnt[1];

  aa_up_rr_arb u_arb (
    .clk (axis_clk),
    .rst (axis_rst),
    .en  (arb_en),
    .req (req),
    .gnt (gnt)
  );

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      data_q  <= data_d;
    end
  end

  // A granted request is already handshaken, so fields are captured in the same cycle.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    be_d    = be_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (gnt[0]) begin
          addr_d  = mb_wr_addr;
          be_d    = mb_wr_be;
          data_d  = mb_wr_data;
          state_d = ST_WR_ADDR;
        end else if (gnt[1]) begin
          data_d  = rd_cpl_data;
          state_d = ST_RD_CPL;
        end
      end
      ST_WR_ADDR: if (as_is_tready) state_d = ST_WR_DATA;
      ST_WR_DATA: if (as_is_tready) state_d = ST_IDLE;
      ST_RD_CPL:  if (as_is_tready) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    addr_ext                  = '0;
    addr_ext[pADDR_WIDTH-1:0] = addr_q;
  end

  always_comb begin
    as_is_tdata  = '0;
    as_is_tstrb  = 4'h0;
    as_is_tkeep  = 4'h0;
    as_is_tlast  = 1'b0;
    as_is_tid    = 2'b00;
    as_is_tuser  = 2'b00;
    as_is_tvalid = 1'b0;
    if (state_q != ST_IDLE) begin
      as_is_tstrb  = 4'hF;
      as_is_tkeep  = 4'hF;
      as_is_tlast  = 1'b1;
      as_is_tid    = TID_UP_AA;
      as_is_tvalid = 1'b1;
    end
    case (state_q)
      ST_WR_ADDR: begin
        as_is_tdata = {be_q, addr_ext};
        as_is_tuser = TUSER_AXILITE_WRITE;
      end
      ST_WR_DATA: begin
        as_is_tdata = data_q;
        as_is_tuser = TUSER_AXILITE_WRITE;
      end
      ST_RD_CPL: begin
        as_is_tdata = data_q;
        as_is_tuser = TUSER_AXILITE_READ_CPL;
      end
      default: ;
    endcase
  end

`ifdef AA_UP_PKT_CNT_EN
  logic [15:0] wr_cnt_q, wr_cnt_d;
  logic [15:0] cpl_cnt_q, cpl_cnt_d;

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    cpl_cnt_d = cpl_cnt_q;
    if (as_is_tready && (state_q == ST_WR_DATA) && (wr_cnt_q != 16'hFFFF)) begin
      wr_cnt_d = wr_cnt_q + 16'd1;
    end
    if (as_is_tready && (state_q == ST_RD_CPL) && (cpl_cnt_q != 16'hFFFF)) begin
      cpl_cnt_d = cpl_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      wr_cnt_q  <= '0;
      cpl_cnt_q <= '0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      cpl_cnt_q <= cpl_cnt_d;
    end
  end

  assign wr_pkt_cnt  = wr_cnt_q;
  assign cpl_pkt_cnt = cpl_cnt_q;
`endif

endmodule

`default_nettype wire
